// File: rtl/clint_timer_pkg.sv
// Shared address map for the SoC slaves plus small helpers used by the CLINT timer.
package clint_timer_pkg;

    localparam logic [31:0] BASERAM_BASE      = 32'h8000_0000;
    localparam logic [31:0] CLINT_BASE        = 32'h0200_0000;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_dat,
                                               input logic [31:0] wr_dat,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_dat;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[i*8 +: 8] = wr_dat[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer_prescaler.sv
// Free-running divider: counts 0..DIV-1, tick_o high in the cycle it wraps.
// Combinational tick, so DIV=1 yields a tick every cycle; no backpressure.
module clint_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick_o = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/clint_timer.sv
// RISC-V CLINT (msip, mtime, mtimecmp) on a Wishbone slave; ack one cycle after accept.
// No stalls: a request is taken whenever ack is low, so back-to-back requests alternate.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int CLK_FREQ  = 10_000_000,
    parameter int TICK_FREQ = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        timer_irq_o,
    output logic        soft_irq_o
);

    localparam int TICK_DIV = CLK_FREQ / TICK_FREQ;

    logic        tick;
    logic        accept;
    logic        wr;
    logic [15:0] offset;
    logic        unused_adr;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q;
    logic        ack_q;
    logic [31:0] rd_dat_q;
    logic [31:0] rdata;
    logic        irq_q;

    clint_prescaler #(.DIV(TICK_DIV)) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tick_o (tick)
    );

    assign accept     = wb_cyc_i && wb_stb_i && !ack_q;
    assign wr         = accept && wb_we_i;
    assign offset     = {wb_adr_i[15:2], 2'b00};
    assign unused_adr = ^{wb_adr_i[31:16], wb_adr_i[1:0]};

    // A software write to either mtime half takes priority and swallows that cycle's tick.
    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wr && offset == CLINT_MTIME_LO) begin
            mtime_d[31:0] = byte_merge(mtime_q[31:0], wb_dat_i, wb_sel_i);
        end else if (wr && offset == CLINT_MTIME_HI) begin
            mtime_d[63:32] = byte_merge(mtime_q[63:32], wb_dat_i, wb_sel_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (wr && offset == CLINT_MTIMECMP_LO) begin
            mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], wb_dat_i, wb_sel_i);
        end else if (wr && offset == CLINT_MTIMECMP_HI) begin
            mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wb_dat_i, wb_sel_i);
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            CLINT_MSIP:        rdata = {31'd0, msip_q};
            CLINT_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
            CLINT_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
            CLINT_MTIME_LO:    rdata = mtime_q[31:0];
            CLINT_MTIME_HI:    rdata = mtime_q[63:32];
            default:           rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            ack_q      <= 1'b0;
            rd_dat_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            if (wr && offset == CLINT_MSIP && wb_sel_i[0]) begin
                msip_q <= wb_dat_i[0];
            end
            ack_q    <= accept;
            // Only loaded on accept, so the bus reads zero whenever ack is low.
            rd_dat_q <= (accept && !wb_we_i) ? rdata : 32'd0;
            irq_q    <= (mtime_q >= mtimecmp_q);
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = rd_dat_q;
    assign timer_irq_o = irq_q;
    assign soft_irq_o  = msip_q;

endmodule
